usb_crc_engine: RTL

USB_CRC_ENGINE -- requirements
Module: usb_crc_engine

---
 rtl/usb_crc_engine.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/usb_crc_engine.sv
`default_nettype none
// ============================================================================
// Module : usb_crc_engine
// Byte-wide reflected (LSB-first) CRC checker/generator; the CRC append stream
// exists only when macro USB_CRC_APPEND_EN is defined.
// Rev    : 1.0
// ============================================================================
module usb_crc_engine #(
    parameter int               CRC_W   = 16,
    parameter logic [CRC_W-1:0] POLY    = 16'h8005,
    parameter logic [CRC_W-1:0] INIT    = {CRC_W{1'b1}},
    parameter logic [CRC_W-1:0] XOROUT  = {CRC_W{1'b1}},
    parameter logic [CRC_W-1:0] RESIDUE = 16'hB001
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             mode,
    input  logic [7:0]       data_in,
    input  logic             data_valid,
    input  logic             data_last,
    output logic [CRC_W-1:0] crc_out,
    output logic             crc_valid,
    output logic             busy,
    output logic             done,
    output logic [7:0]       tx_byte,
    output logic             tx_valid,
    input  logic             tx_ready
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        APPEND = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [CRC_W-1:0] reflect(input logic [CRC_W-1:0] v);
        logic [CRC_W-1:0] r;
        r = '0;
        for (int i = 0; i < CRC_W; i++) begin
            r[i] = v[CRC_W-1-i];
        end
        return r;
    endfunction

    // The register is kept bit-reversed, so the polynomial is too.
    localparam logic [CRC_W-1:0] POLY_REF = reflect(POLY);

    function automatic logic [CRC_W-1:0] crc_byte(input logic [CRC_W-1:0] c,
                                                  input logic [7:0]       b);
        logic [CRC_W-1:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) begin
                r = (r >> 1) ^ POLY_REF;
            end else begin
                r = r >> 1;
            end
        end
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             crc_valid_q, crc_valid_d;

`ifdef USB_CRC_APPEND_EN
    localparam int NB = (CRC_W + 7) / 8;

    logic        mode_q, mode_d;
    logic [1:0]  idx_q, idx_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] crc_out_ext;
`else
    logic        unused_inputs;
    assign unused_inputs = ^{mode, tx_ready};
`endif

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
`ifdef USB_CRC_APPEND_EN
        mode_d  = mode_q;
        idx_d   = idx_q;
`endif
        // start wins over everything, including a byte presented with it
        if (start) begin
            state_d = ACCUM;
            crc_d   = INIT;
`ifdef USB_CRC_APPEND_EN
            mode_d  = mode;
            idx_d   = '0;
`endif
        end else begin
            case (state_q)
                ACCUM: begin
                    if (data_valid) begin
                        crc_d = crc_byte(crc_q, data_in);
                        if (data_last) begin
`ifdef USB_CRC_APPEND_EN
                            state_d = mode_q ? APPEND : DONE;
                            idx_d   = '0;
`else
                            state_d = DONE;
`endif
                        end
                    end
                end
`ifdef USB_CRC_APPEND_EN
                APPEND: begin
                    if (tx_ready) begin
                        if (idx_q == 2'(NB - 1)) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end

        busy_d      = (state_d == ACCUM) || (state_d == APPEND);
        done_d      = (state_d == DONE);
        crc_valid_d = (state_d == DONE) && (crc_d == RESIDUE);
`ifdef USB_CRC_APPEND_EN
        crc_out_ext = 32'(crc_d ^ XOROUT);
        tx_valid_d  = (state_d == APPEND);
        tx_byte_d   = tx_valid_d ? crc_out_ext[{idx_d, 3'b000} +: 8] : 8'h00;
`endif
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            crc_q       <= INIT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            crc_valid_q <= 1'b0;
`ifdef USB_CRC_APPEND_EN
            mode_q      <= 1'b0;
            idx_q       <= '0;
            tx_byte_q   <= 8'h00;
            tx_valid_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            crc_q       <= crc_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            crc_valid_q <= crc_valid_d;
`ifdef USB_CRC_APPEND_EN
            mode_q      <= mode_d;
            idx_q       <= idx_d;
            tx_byte_q   <= tx_byte_d;
            tx_valid_q  <= tx_valid_d;
`endif
        end
    end

    assign crc_out   = crc_q ^ XOROUT;
    assign crc_valid = crc_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
`ifdef USB_CRC_APPEND_EN
    assign tx_byte   = tx_byte_q;
    assign tx_valid  = tx_valid_q;
`else
    assign tx_byte   = 8'h00;
    assign tx_valid  = 1'b0;
`endif

endmodule
`default_nettype wire
